instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream neighbour of the main decoder: owns the PC and fetches 32-bit words from instruction memory over a req/rvalid handshake.
//  Registers the fetched word in the IF stage register. if_opcode (if_instr[6:0]) drives the decoder's Opcode input.
//  Handles stalls from the hazard unit via a 1-entry hold buffer, and branch redirects with flush and dropping of in-flight responses.
// PARAMETERS
//  PC_W      9          PC / imem byte-address width; PC wraps modulo 2**PC_W
//  INS_W     32         instruction width
//  RESET_PC  '0         PC value loaded on reset
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  imem_req     out  1      fetch request; held high until imem_rvalid
//  imem_addr    out  PC_W   request byte address; stable while imem_req=1
//  imem_rvalid  in   1      response valid; only meaningful while imem_req=1
//  imem_rdata   in   INS_W  fetched word, valid with imem_rvalid
//  stall        in   1      decode cannot accept: IF register must hold
//  br_taken     in   1      redirect fetch to br_target and flush IF
//  br_target    in   PC_W   redirect address; bits[1:0] forced to 0
//  if_valid     out  1      IF register holds a real instruction
//  if_pc        out  PC_W   PC of if_instr
//  if_instr     out  INS_W  IF-stage instruction (NOP when invalid)
//  if_opcode    out  7      if_instr[6:0], to decoder Opcode input
// BEHAVIOUR
//  - Reset (any cycle, including mid-request): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP (32'h00000013), hold buffer empty. Any outstanding response is ignored.
//  - FSM states and imem_req per state:
//    IDLE (req=0), WAIT (req=1, addr=req_addr), HOLD (req=0), DROP (req=1, addr=old req_addr).
//  - IDLE -> WAIT unconditionally (first request one cycle after reset falls).
//  - WAIT, rvalid=1, no branch, stall=0:
//    if_instr<=rdata, if_pc<=req_addr, if_valid<=1; pc, req_addr<=req_addr+4; stay in WAIT.
//    Zero-wait memory therefore gives 1 instruction per cycle.
//  - WAIT, rvalid=1, no branch, stall=1: rdata goes to the hold buffer (with its PC); IF register unchanged; -> HOLD.
//  - WAIT, rvalid=0: if stall=0, if_valid<=0 and if_instr<=NOP (bubble); if stall=1, IF register holds.
//  - HOLD, stall=0: hold buffer moves into the IF register; pc, req_addr<=+4; -> WAIT. HOLD, stall=1: everything holds.
//  - br_taken (priority over stall and rvalid, in every state except IDLE):
//    flush, i.e. if_valid<=0, if_instr<=NOP; hold buffer cleared; pc<=br_target&~3.
//    - WAIT with rvalid=1, or HOLD: req_addr<=target; -> WAIT.
//    - WAIT with rvalid=0: the request stays outstanding; -> DROP.
//  - DROP: req stays high on the old address. On rvalid the response is discarded, req_addr<=pc, -> WAIT.
//    A further br_taken while in DROP only updates pc.
//  - br_taken in IDLE: pc, req_addr<=target&~3; -> WAIT.
//  - Arithmetic: pc+4 is computed in PC_W bits with silent wrap (max address wraps to 0). No misalignment exceptions.
//  - Invariants:
//    - imem_addr never changes while imem_req=1 and rvalid=0.
//    - At most one outstanding request.
//    - A discarded or flushed word never reaches if_valid=1.
// STRUCTURE
//  - riscv_pkg: NOP_INSTR, the OPC_* opcode constants shared with the decoder, typedef enum logic[1:0] fetch_state_t {IDLE,WAIT,HOLD,DROP}.
//  - One sub-module, fetch_hold_buf: 1-entry {pc,instr} skid buffer with load/clear/valid.
//  - The FSM, PC register and IF register stay in instr_fetch_unit.
// TESTING
//  1. Reset, zero-wait memory returning addr-tagged words:
//     if_pc sequence 0,4,8,... on consecutive cycles; first if_valid in the 2nd cycle after reset falls.
//  2. rvalid delayed 3 cycles on addr 8: imem_addr held at 8 for all 4 cycles; exactly 3 bubbles with if_instr=NOP.
//  3. stall=1 for 2 cycles while rvalid arrives for addr 12:
//     IF register holds the addr-8 word; after stall drops, addr-12 word appears once; no word lost or duplicated.
//  4. br_taken to 0x41 while request for 16 pending:
//     DROP entered; response for 16 discarded; next imem_addr=0x40; if_valid=0 until the 0x40 word arrives.
//  5. br_taken and rvalid in same cycle, with stall=1: the word is dropped, the flush still happens, next request goes to the target.
//  6. PC_W=9, branch to 0x1FC: next fetch after 0x1FC is 0x000; reset asserted mid-WAIT returns to IDLE with pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch/decode definitions: NOP encoding, major opcodes and fetch FSM states.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0]  OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0]  OPC_STORE  = 7'b010_0011;
    localparam logic [6:0]  OPC_OP     = 7'b011_0011;
    localparam logic [6:0]  OPC_LUI    = 7'b011_0111;
    localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0]  OPC_JALR   = 7'b110_0111;
    localparam logic [6:0]  OPC_JAL    = 7'b110_1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} skid buffer catching a fetched word while decode is stalled.
module fetch_hold_buf #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [INS_W-1:0] instr_in,
    output logic             valid,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] instr
);
    logic             valid_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [INS_W-1:0] instr_reg;

    // Clear wins over load: a flush must never let a captured word survive.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            pc_reg    <= pc_in;
            instr_reg <= instr_in;
        end
    end

    assign valid = valid_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;
endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and IF stage: fetches words over req/rvalid, holds them across stalls, flushes on redirects.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [PC_W-1:0]      br_target,
    output logic                 if_valid,
    output logic [PC_W-1:0]      if_pc,
    output logic [INS_W-1:0]     if_instr,
    output logic [6:0]           if_opcode
);
    fetch_state_t     state_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  req_addr_reg;
    logic             req_reg;
    logic             if_valid_reg;
    logic [PC_W-1:0]  if_pc_reg;
    logic [INS_W-1:0] if_instr_reg;

    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  addr_inc;
    logic             hb_load;
    logic             hb_clear;
    logic             hb_valid;
    logic [PC_W-1:0]  hb_pc;
    logic [INS_W-1:0] hb_instr;

    assign target   = {br_target[PC_W-1:2], 2'b00};
    assign addr_inc = req_addr_reg + PC_W'(4);

    always_comb begin
        hb_load  = 1'b0;
        hb_clear = 1'b0;
        if (state_reg == WAIT && imem.imem_rvalid && !br_taken && stall)
            hb_load = 1'b1;
        if (state_reg != IDLE && br_taken)
            hb_clear = 1'b1;
        if (state_reg == HOLD && !stall)
            hb_clear = 1'b1;
    end

    fetch_hold_buf #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_hold_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (hb_load),
        .clear    (hb_clear),
        .pc_in    (req_addr_reg),
        .instr_in (imem.imem_rdata),
        .valid    (hb_valid),
        .pc       (hb_pc),
        .instr    (hb_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            req_addr_reg <= RESET_PC;
            req_reg      <= 1'b0;
            if_valid_reg <= 1'b0;
            if_pc_reg    <= '0;
            if_instr_reg <= NOP_INSTR;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (br_taken) begin
                        pc_reg       <= target;
                        req_addr_reg <= target;
                    end
                    state_reg <= WAIT;
                    req_reg   <= 1'b1;
                end
                WAIT: begin
                    if (br_taken) begin
                        if_valid_reg <= 1'b0;
                        if_instr_reg <= NOP_INSTR;
                        pc_reg       <= target;
                        if (imem.imem_rvalid) begin
                            req_addr_reg <= target;
                        end else begin
                            // Request still outstanding: its response must be swallowed in DROP.
                            state_reg <= DROP;
                        end
                    end else if (imem.imem_rvalid) begin
                        if (!stall) begin
                            if_valid_reg <= 1'b1;
                            if_pc_reg    <= req_addr_reg;
                            if_instr_reg <= imem.imem_rdata;
                            pc_reg       <= addr_inc;
                            req_addr_reg <= addr_inc;
                        end else begin
                            state_reg <= HOLD;
                            req_reg   <= 1'b0;
                        end
                    end else if (!stall) begin
                        if_valid_reg <= 1'b0;
                        if_instr_reg <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        if_valid_reg <= 1'b0;
                        if_instr_reg <= NOP_INSTR;
                        pc_reg       <= target;
                        req_addr_reg <= target;
                        state_reg    <= WAIT;
                        req_reg      <= 1'b1;
                    end else if (!stall && hb_valid) begin
                        if_valid_reg <= 1'b1;
                        if_pc_reg    <= hb_pc;
                        if_instr_reg <= hb_instr;
                        pc_reg       <= addr_inc;
                        req_addr_reg <= addr_inc;
                        state_reg    <= WAIT;
                        req_reg      <= 1'b1;
                    end
                end
                DROP: begin
                    if (br_taken)
                        pc_reg <= target;
                    if (imem.imem_rvalid) begin
                        req_addr_reg <= br_taken ? target : pc_reg;
                        state_reg    <= WAIT;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_reg;
    assign imem.imem_addr = req_addr_reg;
    assign if_valid       = if_valid_reg;
    assign if_pc          = if_pc_reg;
    assign if_instr       = if_instr_reg;
    assign if_opcode      = if_instr_reg[6:0];
endmodule
